// File: rtl/fsm_trenes_planta_pkg.sv
// Shared definitions for the two-track crossing plant: track states, track indices, default crossing time.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package trenes_pkg;

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    ESPERA = 2'd1,
    CRUZA  = 2'd2
  } estado_t;

  localparam int VIA0 = 0;
  localparam int VIA1 = 1;

  localparam int CRUCE_CICLOS_DEF = 4;

  // True when switch position b routes traffic onto track 'via'
  function automatic logic via_sel(input int via, input logic b);
    return b == (via == VIA1);
  endfunction

endpackage

// File: rtl/fsm_trenes_planta_via.sv
// One track of the crossing plant: LIBRE/ESPERA/CRUZA FSM, one-deep pending slot, crossing timer, passed counter.
// Latency: arrival to V is 1 cycle; grant to cruzando is 1 cycle; V lasts CRUCE_CICLOS cycles after the grant edge.
// Backpressure: none; a second arrival while the pending slot is full is dropped and flagged on sticky perdido.
module fsm_trenes_via
  import trenes_pkg::*;
#(
  parameter int CRUCE_CICLOS = CRUCE_CICLOS_DEF,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arr,
  input  logic             T,
  input  logic             sel_ok,
  output logic             V,
  output logic             cruzando,
  output logic [CNT_W-1:0] pasados,
  output logic             perdido
);

  localparam int CW = (CRUCE_CICLOS > 1) ? $clog2(CRUCE_CICLOS) : 1;

  estado_t       estado;
  logic          pend;
  logic [CW-1:0] cnt;

  // Track FSM with registered sensor/crossing outputs, pending slot and sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= LIBRE;
      V        <= 1'b0;
      cruzando <= 1'b0;
      pend     <= 1'b0;
      cnt      <= '0;
      pasados  <= '0;
      perdido  <= 1'b0;
    end else begin
      case (estado)
        LIBRE: begin
          if (arr || pend) begin
            estado <= ESPERA;
            V      <= 1'b1;
            // The pending train is consumed; a simultaneous new arrival takes its slot
            pend   <= pend & arr;
          end
        end
        ESPERA: begin
          if (T && sel_ok) begin
            estado   <= CRUZA;
            cruzando <= 1'b1;
            cnt      <= CW'(CRUCE_CICLOS - 1);
          end
        end
        CRUZA: begin
          // Signal withdrawal is ignored: a train already on the crossing keeps going
          if (cnt == '0) begin
            estado   <= LIBRE;
            V        <= 1'b0;
            cruzando <= 1'b0;
            pasados  <= pasados + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          estado   <= LIBRE;
          V        <= 1'b0;
          cruzando <= 1'b0;
        end
      endcase

      // Arrivals while the track is occupied go to the pending slot, or are lost if it is full
      if (arr && (estado != LIBRE)) begin
        if (pend) begin
          perdido <= 1'b1;
        end else begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fsm_trenes_planta.sv
// Track-side plant for the two-track crossing controller; optional wait timeout under macro TRENES_TIMEOUT_EN.
// Latency: arrival to V0/V1 is 1 cycle; grant to status is 1 cycle; choque/timeout register on the offending edge.
// Backpressure: none; surplus arrivals are dropped and flagged on sticky perdido.
module fsm_trenes_planta
  import trenes_pkg::*;
#(
  parameter int CRUCE_CICLOS = CRUCE_CICLOS_DEF,
  parameter int CNT_W        = 8
`ifdef TRENES_TIMEOUT_EN
  ,
  parameter int ESPERA_MAX   = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arr0,
  input  logic             arr1,
  input  logic             T0,
  input  logic             T1,
  input  logic             B,
  output logic             V0,
  output logic             V1,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] pasados0,
  output logic [CNT_W-1:0] pasados1,
  output logic             choque,
  output logic             perdido
`ifdef TRENES_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  logic sel_ok0, sel_ok1;
  logic cruzando0, cruzando1;
  logic perdido0, perdido1;

  assign sel_ok0 = via_sel(VIA0, B);
  assign sel_ok1 = via_sel(VIA1, B);

  fsm_trenes_via #(
    .CRUCE_CICLOS (CRUCE_CICLOS),
    .CNT_W        (CNT_W)
  ) u_via0 (
    .clk      (clk),
    .reset    (reset),
    .arr      (arr0),
    .T        (T0),
    .sel_ok   (sel_ok0),
    .V        (V0),
    .cruzando (cruzando0),
    .pasados  (pasados0),
    .perdido  (perdido0)
  );

  fsm_trenes_via #(
    .CRUCE_CICLOS (CRUCE_CICLOS),
    .CNT_W        (CNT_W)
  ) u_via1 (
    .clk      (clk),
    .reset    (reset),
    .arr      (arr1),
    .T        (T1),
    .sel_ok   (sel_ok1),
    .V        (V1),
    .cruzando (cruzando1),
    .pasados  (pasados1),
    .perdido  (perdido1)
  );

  assign status  = {cruzando1, cruzando0};
  assign perdido = perdido0 | perdido1;

  // Sticky collision flag: both tracks crossing, or a crossing track with the switch set against it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      choque <= 1'b0;
    end else if ((cruzando0 && cruzando1) ||
                 (cruzando0 && !sel_ok0) ||
                 (cruzando1 && !sel_ok1)) begin
      choque <= 1'b1;
    end
  end

`ifdef TRENES_TIMEOUT_EN
  localparam int EW = (ESPERA_MAX > 1) ? $clog2(ESPERA_MAX) : 1;

  logic          espera0, espera1;
  logic [EW-1:0] esp0, esp1;

  // A track is waiting when its sensor is on but it is not yet crossing
  assign espera0 = V0 & ~cruzando0;
  assign espera1 = V1 & ~cruzando1;

  // Per-track wait counters, saturating one below the limit; the sticky flag fires when the limit is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      esp0    <= '0;
      esp1    <= '0;
      timeout <= 1'b0;
    end else begin
      if (!espera0) begin
        esp0 <= '0;
      end else if (esp0 != EW'(ESPERA_MAX - 1)) begin
        esp0 <= esp0 + 1'b1;
      end
      if (!espera1) begin
        esp1 <= '0;
      end else if (esp1 != EW'(ESPERA_MAX - 1)) begin
        esp1 <= esp1 + 1'b1;
      end
      if ((espera0 && esp0 == EW'(ESPERA_MAX - 1)) ||
          (espera1 && esp1 == EW'(ESPERA_MAX - 1))) begin
        timeout <= 1'b1;
      end
    end
  end
`endif

endmodule
